control_unit_pipe: RTL
======================

# control_unit_pipe

Registered ID-stage control decoder that maps an instruction opcode to the ID/EX control bundle, one cycle after the opcode is presented. Generalises the single-cycle decoder with parametrised opcode/ALU-op widths, a multi-cycle branch flush sequencer, stall hold, an input valid qualifier and illegal-opcode reporting. Sits between the IF/ID register and the ID/EX register; its outputs are the ID/EX control fields.

## Interface
- `OPCODE_W`, 6: opcode width, 6 or more. Decoded values are zero-extended to this width.
- `ALUOP_W`, 2: ALU-op field width, 2 or more. Encodings are zero-extended.
- `FLUSH_CYCLES`, 1: bubbles emitted per flush request, 1..7.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `opcode` in OPCODE_W: opcode from the IF/ID register.
- `id_valid` in 1: the IF/ID slot holds a real instruction.
- `stall` in 1: hazard unit load-use stall. Hold all outputs.
- `flush` in 1: taken branch or jump resolved in EX/MEM. Squash.
- `reg_dst`, `branch`, `mem_read`, `mem_to_reg`, `mem_write`, `alu_src`, `reg_write`, `jump` out 1 each: control bits.
- `alu_op` out ALUOP_W: ALU control class.
- `ctrl_valid` out 1: the bundle is a real instruction, not a bubble.
- `illegal_op` out 1: one-cycle pulse when a valid opcode is not decodable.
- `flushing` out 1: high while the block is in FLUSH state.

## Operation
Opcode decode, listed as reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, jump, alu_op:
- RTYPE 0x00: 1,0,0,0,0,0,1,0, alu_op 2.
- LW 0x01: 0,0,1,1,0,1,1,0, alu_op 0.
- SW 0x02: 0,0,0,0,1,1,0,0, alu_op 0.
- BEQ 0x03: 0,1,0,0,0,0,0,0, alu_op 1.
- ADDI 0x04: 0,0,0,0,0,1,1,0, alu_op 0.
- JUMP 0x05: 0,0,0,0,0,0,0,1, alu_op 0.

Bubble: all control bits 0, alu_op 0, ctrl_valid 0. Don't-care fields of SW and BEQ are driven 0.

States:
- RUN to FLUSH when `flush`=1. Load counter with FLUSH_CYCLES-1 and register a bubble.
- FLUSH decrements the counter each edge and registers a bubble. It returns to RUN on the edge where counter=0 and `flush`=0.
- `flush` while in FLUSH reloads the counter to FLUSH_CYCLES-1.

Edge priority in RUN:
1. `flush`: bubble.
2. `stall`: all outputs hold, illegal_op forced 0.
3. `id_valid`=0: bubble.
4. Legal opcode: decoded bundle, ctrl_valid=1.
5. Illegal opcode: bubble, illegal_op=1 for one cycle.

`stall` is ignored in FLUSH; bubbles are emitted regardless.

## Timing
- Reset low: asynchronously force bubble, illegal_op=0, flushing=0, state RUN, counter 0.
- After reset deassertion, the first rising edge decodes normally.
- Latency: opcode sampled at edge N appears at outputs after edge N. No combinational input-to-output path.
- Flush asserted at edge N gives bubbles at edges N..N+FLUSH_CYCLES-1. The first decode is at edge N+FLUSH_CYCLES if `flush` stays low.
- `flushing` is 1 from edge N through edge N+FLUSH_CYCLES-1. With FLUSH_CYCLES=1 it is a one-cycle pulse.
- `flush` and `stall` in the same cycle: flush wins and the stall is dropped.
- Reset asserted mid-flush aborts the sequence immediately.

## Configuration
- `CONTROL_UNIT_BNE_EN` defined: opcode 0x06 (BNE) decodes as 0,1,0,0,0,0,0,0 with alu_op 3. The EX branch logic uses alu_op 3 to invert the zero test.
- Undefined: opcode 0x06 is illegal, producing a bubble and an illegal_op pulse.

## Test plan
- Reset low mid-stream with opcode 0x00 held: all outputs 0 immediately. After release, the next edge gives reg_dst=1, reg_write=1, alu_op=2, ctrl_valid=1.
- Sequence LW, SW, BEQ, ADDI, JUMP, each with id_valid=1: each bundle appears exactly one edge later and matches the decode list.
- FLUSH_CYCLES=3, ADDI stream, flush pulsed one cycle: exactly 3 bubbles and flushing high for 3 edges, then ADDI again. A second flush during the 2nd bubble extends the sequence to 2+3 bubbles total.
- LW decoded, then stall=1 for 2 cycles while opcode changes to 0x00: LW bundle held for 2 extra cycles. Stall and flush together: bubble.
- Opcode 0x3F valid: bubble and a one-cycle illegal_op pulse. Opcode 0x3F with id_valid=0: bubble, illegal_op stays 0.
- Opcode 0x06 with CONTROL_UNIT_BNE_EN defined: branch=1, alu_op=3, ctrl_valid=1. Without it: illegal_op=1.

Source files
------------

// File: rtl/control_unit_pipe.sv
// control_unit_pipe
//   Registered ID-stage control decoder. Maps the IF/ID opcode to the ID/EX
//   control bundle one clock after it is sampled. It also runs a multi-cycle
//   flush sequencer, holds its outputs on stall, qualifies decode with
//   id_valid and pulses illegal_op for undecodable opcodes.
//
//   Optional feature: define CONTROL_UNIT_BNE_EN to decode opcode 0x06 (BNE)
//   with alu_op 3. When it is undefined, 0x06 is an illegal opcode.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_RUN  | normal decode: flush > stall > !id_valid > legal > illegal
//   S_FLUSH| emitting bubbles; cnt_q counts the bubbles still to come
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset
//   opcode       in   opcode from IF/ID (OPCODE_W bits)
//   id_valid     in   IF/ID slot holds a real instruction
//   stall        in   load-use stall; hold all outputs
//   flush        in   taken branch/jump; squash
//   reg_dst .. jump   out  control bits
//   alu_op       out  ALU control class (ALUOP_W bits)
//   ctrl_valid   out  bundle is a real instruction
//   illegal_op   out  one-cycle pulse for a valid, undecodable opcode
//   flushing     out  high while in S_FLUSH
module control_unit_pipe #(
  parameter int OPCODE_W     = 6,
  parameter int ALUOP_W      = 2,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                id_valid,
  input  logic                stall,
  input  logic                flush,
  output logic                reg_dst,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_to_reg,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_write,
  output logic                jump,
  output logic [ALUOP_W-1:0]  alu_op,
  output logic                ctrl_valid,
  output logic                illegal_op,
  output logic                flushing
);

  // Bundle layout, MSB first:
  // reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write,
  // jump, alu_op, ctrl_valid. An all-zero bundle is a bubble.
  localparam int BW = 9 + ALUOP_W;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(0);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(1);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(2);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(3);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(4);
  localparam logic [OPCODE_W-1:0] OP_JUMP  = OPCODE_W'(5);
`ifdef CONTROL_UNIT_BNE_EN
  localparam logic [OPCODE_W-1:0] OP_BNE   = OPCODE_W'(6);
`endif

  localparam logic [2:0] CNT_LOAD = 3'(FLUSH_CYCLES - 1);

  typedef enum logic {
    S_RUN,
    S_FLUSH
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [BW-1:0] bundle_q, bundle_d;
  logic          illegal_q, illegal_d;
  logic [BW-1:0] dec_bundle;
  logic          dec_legal;
  logic          do_decode;

  // Pure opcode decode. Don't-care fields of SW and BEQ are driven 0.
  always_comb begin
    dec_bundle = '0;
    dec_legal  = 1'b1;
    case (opcode)
      OP_RTYPE: dec_bundle = {8'b1000_0010, ALUOP_W'(2), 1'b1};
      OP_LW:    dec_bundle = {8'b0011_0110, ALUOP_W'(0), 1'b1};
      OP_SW:    dec_bundle = {8'b0000_1100, ALUOP_W'(0), 1'b1};
      OP_BEQ:   dec_bundle = {8'b0100_0000, ALUOP_W'(1), 1'b1};
      OP_ADDI:  dec_bundle = {8'b0000_0110, ALUOP_W'(0), 1'b1};
      OP_JUMP:  dec_bundle = {8'b0000_0001, ALUOP_W'(0), 1'b1};
`ifdef CONTROL_UNIT_BNE_EN
      // alu_op 3 tells the EX branch logic to invert the zero test.
      OP_BNE:   dec_bundle = {8'b0100_0000, ALUOP_W'(3), 1'b1};
`endif
      default:  dec_legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bundle_d  = bundle_q;
    illegal_d = 1'b0;
    do_decode = 1'b0;

    case (state_q)
      S_RUN: begin
        if (flush) begin
          state_d  = S_FLUSH;
          cnt_d    = CNT_LOAD;
          bundle_d = '0;
        end else if (!stall) begin
          do_decode = 1'b1;
        end
        // stall: bundle holds, illegal_op stays 0
      end
      S_FLUSH: begin
        // stall has no effect here; the flush always runs to completion
        if (flush) begin
          cnt_d    = CNT_LOAD;
          bundle_d = '0;
        end else if (cnt_q != 3'd0) begin
          cnt_d    = cnt_q - 3'd1;
          bundle_d = '0;
        end else begin
          // Last flush edge doubles as the first normal decode.
          state_d   = S_RUN;
          do_decode = 1'b1;
        end
      end
      default: begin
        state_d  = S_RUN;
        cnt_d    = 3'd0;
        bundle_d = '0;
      end
    endcase

    if (do_decode) begin
      if (!id_valid) begin
        bundle_d = '0;
      end else if (dec_legal) begin
        bundle_d = dec_bundle;
      end else begin
        bundle_d  = '0;
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_RUN;
      cnt_q     <= 3'd0;
      bundle_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bundle_q  <= bundle_d;
      illegal_q <= illegal_d;
    end
  end

  assign {reg_dst, branch, mem_read, mem_to_reg, mem_write, alu_src,
          reg_write, jump, alu_op, ctrl_valid} = bundle_q;
  assign illegal_op = illegal_q;
  assign flushing   = (state_q == S_FLUSH);

endmodule
